dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
// - Shares the single data-memory port between the pipeline MEM stage (requester P, fixed high priority) and a debug/loader port (requester D).
// - Sits between EX/MEM register outputs and the data memory: P never waits; D is granted only in cycles where P does not touch memory.
// - A starvation counter raises a pipeline stall request so that D is guaranteed progress.
// PARAMETERS
// DATA_W      32  data width
// DM_ADDRESS  9   data-memory address width
// STARVE_MAX  8   consecutive WAIT cycles before stall_req asserts (>=1)
// PORTS
// clk         in   1           clock, all state on rising edge
// reset       in   1           asynchronous, active-low reset
// pipe_rd     in   1           MEM-stage read enable
// pipe_wr     in   1           MEM-stage write enable
// pipe_addr   in   DM_ADDRESS  MEM-stage address
// pipe_wdata  in   DATA_W      MEM-stage write data
// pipe_func3  in   3           MEM-stage access size/sign
// pipe_rdata  out  DATA_W      read data to MEM/WB (= mem_rdata, combinational)
// dbg_req     in   1           debug request, held until dbg_gnt
// dbg_we      in   1           1 = write, 0 = read
// dbg_addr    in   DM_ADDRESS  debug address
// dbg_wdata   in   DATA_W      debug write data
// dbg_func3   in   3           debug access size/sign
// dbg_gnt     out  1           combinational pulse: debug access performed this cycle
// dbg_rvalid  out  1           registered: dbg_rdata valid (1 cycle after a read grant)
// dbg_rdata   out  DATA_W      registered debug read data
// stall_req   out  1           registered: request to freeze PC/IF and bubble ID/EX
// mem_rd      out  1           to data memory
// mem_wr      out  1           to data memory
// mem_addr    out  DM_ADDRESS  to data memory
// mem_wdata   out  DATA_W      to data memory
// mem_func3   out  3           to data memory
// mem_rdata   in   DATA_W      from data memory, valid same cycle as address
// BEHAVIOUR
// - Reset (reset=0, async): FSM=IDLE, wait counter=0; stall_req, dbg_rvalid = 0; dbg_rdata = 0.
// - pipe_act = pipe_rd | pipe_wr. Both high: write performed; read data is still returned.
// - Memory mux (combinational): pipe_act -> mem_* = pipe_*; else dbg_gnt -> mem_* = dbg_* (mem_wr = dbg_we, mem_rd = ~dbg_we); else mem_rd = mem_wr = 0, addr/wdata/func3 = 0.
// - dbg_gnt = dbg_req & ~pipe_act, in any state. Zero-latency grant when the port is free.
// - FSM, evaluated each edge:
//   IDLE : dbg_req & pipe_act -> WAIT, cnt = 1; otherwise stay in IDLE.
//   WAIT : dbg_gnt or ~dbg_req -> IDLE, cnt = 0.
//          Else if cnt == STARVE_MAX -> STALL, stall_req = 1.
//          Else cnt++.
//   STALL: dbg_gnt or ~dbg_req -> IDLE, cnt = 0, stall_req = 0; otherwise hold.
// - stall_req is high exactly while FSM == STALL. In-flight MEM ops drain, then the port frees.
// - Read grant: next edge sets dbg_rvalid = 1 and dbg_rdata = mem_rdata (at grant).
//   Otherwise dbg_rvalid = 0 next edge and dbg_rdata holds.
// - Write grant: dbg_rvalid stays 0; completion is the dbg_gnt pulse.
// - Back-to-back: dbg_req held high after a grant is a new transaction. It can be granted on the next free cycle; rvalid may be high in the same cycle.
// - dbg_req withdrawn before grant: legal. Return to IDLE, drop stall_req, no memory access.
// - Counter width $clog2(STARVE_MAX+1). It saturates at STARVE_MAX and never wraps.
// - Reset mid-stall or mid-read: outputs clear immediately (async); the pending read is lost.
// - pipe_* pass through with no added latency; arbiter never stalls P.
// TESTING
// 1. Idle pipe; dbg read addr 0x010 (mem=0xDEADBEEF) -> dbg_gnt same cycle; next cycle dbg_rvalid=1, dbg_rdata=0xDEADBEEF.
// 2. pipe_wr held 3 cycles, dbg_req write 0x55 @0x020 -> mem follows pipe for 3 cycles; dbg_gnt cycle 4, mem_wr=1, mem_addr=0x020, mem_wdata=0x55.
// 3. pipe_act held continuously, dbg_req held, STARVE_MAX=8 -> stall_req rises after 8 WAIT cycles. Drop pipe_act -> dbg_gnt that cycle, stall_req=0 next.
// 4. In WAIT with cnt=5, deassert dbg_req -> IDLE next edge, cnt=0, no grant, stall_req never set.
// 5. Assert reset=0 asynchronously during STALL with a read pending -> stall_req, dbg_rvalid, dbg_rdata = 0 before the next edge; IDLE after release.
// 6. pipe_rd & pipe_wr both high -> mem_wr=1; pipe_rdata=mem_rdata; dbg_gnt=0.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Shares the data-memory port between the MEM stage (always wins) and a debug/loader port.
// A starvation counter requests a pipeline stall so the debug side is guaranteed progress.
//
// state | meaning
// IDLE  | no debug request is being held off
// WAIT  | debug request pending behind MEM traffic; cnt counts blocked cycles
// STALL | starvation limit hit; stall_req high until the debug access is granted or withdrawn
module dmem_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9,
    parameter int STARVE_MAX = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pipe_rd,
    input  logic                  pipe_wr,
    input  logic [DM_ADDRESS-1:0] pipe_addr,
    input  logic [DATA_W-1:0]     pipe_wdata,
    input  logic [2:0]            pipe_func3,
    output logic [DATA_W-1:0]     pipe_rdata,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [DM_ADDRESS-1:0] dbg_addr,
    input  logic [DATA_W-1:0]     dbg_wdata,
    input  logic [2:0]            dbg_func3,
    output logic                  dbg_gnt,
    output logic                  dbg_rvalid,
    output logic [DATA_W-1:0]     dbg_rdata,
    output logic                  stall_req,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [2:0]            mem_func3,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STALL} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             pipe_act;
    logic             dbg_rd_gnt;

    assign pipe_act   = pipe_rd | pipe_wr;
    assign dbg_gnt    = dbg_req & ~pipe_act;
    assign dbg_rd_gnt = dbg_gnt & ~dbg_we;
    assign pipe_rdata = mem_rdata;

    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_func3 = '0;
        if (pipe_act) begin
            mem_rd    = pipe_rd;
            mem_wr    = pipe_wr;
            mem_addr  = pipe_addr;
            mem_wdata = pipe_wdata;
            mem_func3 = pipe_func3;
        end else if (dbg_gnt) begin
            mem_rd    = ~dbg_we;
            mem_wr    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            mem_func3 = dbg_func3;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (dbg_req && pipe_act) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (dbg_gnt || !dbg_req) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_W'(STARVE_MAX)) begin
                    state_nxt = S_STALL;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_STALL: begin
                // cnt stays saturated at STARVE_MAX while stalled
                if (dbg_gnt || !dbg_req) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            stall_req  <= 1'b0;
            dbg_rvalid <= 1'b0;
            dbg_rdata  <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            stall_req  <= (state_nxt == S_STALL);
            dbg_rvalid <= dbg_rd_gnt;
            if (dbg_rd_gnt) begin
                dbg_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: table of combinational mux vectors plus hand-written
// starvation/withdraw/reset sequences; debug read data is tracked through a queue.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_rd, pipe_wr;
    logic [8:0]  pipe_addr;
    logic [31:0] pipe_wdata;
    logic [2:0]  pipe_func3;
    logic [31:0] pipe_rdata;
    logic        dbg_req, dbg_we;
    logic [8:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic [2:0]  dbg_func3;
    logic        dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        stall_req;
    logic        mem_rd, mem_wr;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_func3;
    logic [31:0] mem_rdata;

    dmem_port_arbiter #(.DATA_W(32), .DM_ADDRESS(9), .STARVE_MAX(8)) dut (
        .clk(clk), .reset(reset),
        .pipe_rd(pipe_rd), .pipe_wr(pipe_wr), .pipe_addr(pipe_addr),
        .pipe_wdata(pipe_wdata), .pipe_func3(pipe_func3), .pipe_rdata(pipe_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_func3(dbg_func3), .dbg_gnt(dbg_gnt),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .stall_req(stall_req),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_func3(mem_func3), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        prd, pwr;
        logic [8:0]  paddr;
        logic [31:0] pwdata;
        logic [2:0]  pf3;
        logic        dreq, dwe;
        logic [8:0]  daddr;
        logic [31:0] dwdata;
        logic [2:0]  df3;
        logic [31:0] mrdata;
        logic        erd, ewr;
        logic [8:0]  eaddr;
        logic [31:0] ewdata;
        logic [2:0]  ef3;
        logic        egnt;
    } vec_t;

    vec_t        vecs [8];
    int          n_vec  = 0;
    int          n_miss = 0;
    logic [31:0] sb [$];
    logic        exp_rv     = 1'b0;
    logic        exp_rv_nxt = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        pipe_rd = 0; pipe_wr = 0; pipe_addr = '0; pipe_wdata = '0; pipe_func3 = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_func3 = '0;
        mem_rdata = '0;
    endtask

    task automatic forget_pending();
        sb.delete();
        exp_rv     = 1'b0;
        exp_rv_nxt = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        forget_pending();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        exp_rv     = exp_rv_nxt;
        exp_rv_nxt = 1'b0;
        #1;
    endtask

    task automatic at_sample();
        logic [31:0] want;
        @(negedge clk);
        chk("dbg_rvalid", 32'(dbg_rvalid), 32'(exp_rv));
        if (dbg_rvalid) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL dbg_rdata: rvalid with no read outstanding (t=%0t)", $time);
            end else begin
                want = sb.pop_front();
                chk("dbg_rdata", dbg_rdata, want);
            end
        end
    endtask

    task automatic note_grant(input logic gnt, input logic we, input logic [31:0] rdata);
        if (gnt && !we) begin
            exp_rv_nxt = 1'b1;
            sb.push_back(rdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0,0,9'h000,32'h0,3'd0, 0,0,9'h000,32'h0,3'd0, 32'h00001234,
                    0,0,9'h000,32'h0,3'd0, 0};
        vecs[1] = '{1,0,9'h004,32'h0000AAAA,3'd2, 0,0,9'h000,32'h0,3'd0, 32'h00005555,
                    1,0,9'h004,32'h0000AAAA,3'd2, 0};
        vecs[2] = '{0,1,9'h1FF,32'hCAFEF00D,3'd2, 1,0,9'h010,32'h11,3'd4, 32'h0,
                    0,1,9'h1FF,32'hCAFEF00D,3'd2, 0};
        vecs[3] = '{0,0,9'h000,32'h0,3'd0, 1,0,9'h010,32'h11,3'd4, 32'hDEADBEEF,
                    1,0,9'h010,32'h11,3'd4, 1};
        vecs[4] = '{0,0,9'h000,32'h0,3'd0, 1,1,9'h020,32'h55,3'd2, 32'h00000099,
                    0,1,9'h020,32'h55,3'd2, 1};
        vecs[5] = '{1,1,9'h0AB,32'h77,3'd1, 1,0,9'h033,32'h0,3'd5, 32'h87654321,
                    1,1,9'h0AB,32'h77,3'd1, 0};
        vecs[6] = '{0,0,9'h000,32'h0,3'd0, 1,0,9'h033,32'h0,3'd5, 32'h0BADF00D,
                    1,0,9'h033,32'h0,3'd5, 1};
        vecs[7] = '{0,0,9'h000,32'h0,3'd0, 0,0,9'h000,32'h0,3'd0, 32'h0,
                    0,0,9'h000,32'h0,3'd0, 0};

        clear_inputs();
        reset = 1'b0;
        #3;
        chk("reset stall_req", 32'(stall_req), 32'h0);
        chk("reset dbg_rvalid", 32'(dbg_rvalid), 32'h0);
        chk("reset dbg_rdata", dbg_rdata, 32'h0);
        do_reset();

        // combinational mux / grant table
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            pipe_rd = vecs[i].prd; pipe_wr = vecs[i].pwr; pipe_addr = vecs[i].paddr;
            pipe_wdata = vecs[i].pwdata; pipe_func3 = vecs[i].pf3;
            dbg_req = vecs[i].dreq; dbg_we = vecs[i].dwe; dbg_addr = vecs[i].daddr;
            dbg_wdata = vecs[i].dwdata; dbg_func3 = vecs[i].df3; mem_rdata = vecs[i].mrdata;
            at_sample();
            chk($sformatf("v%0d mem_rd", i), 32'(mem_rd), 32'(vecs[i].erd));
            chk($sformatf("v%0d mem_wr", i), 32'(mem_wr), 32'(vecs[i].ewr));
            chk($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].eaddr));
            chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].ewdata);
            chk($sformatf("v%0d mem_func3", i), 32'(mem_func3), 32'(vecs[i].ef3));
            chk($sformatf("v%0d dbg_gnt", i), 32'(dbg_gnt), 32'(vecs[i].egnt));
            chk($sformatf("v%0d pipe_rdata", i), pipe_rdata, vecs[i].mrdata);
            note_grant(vecs[i].egnt, vecs[i].dwe, vecs[i].mrdata);
        end

        // debug write held off by three pipe writes, granted on the fourth cycle
        do_reset();
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            pipe_wr = (i < 3); pipe_addr = 9'(9'h100 + i); pipe_wdata = 32'(i + 1);
            dbg_req = 1; dbg_we = 1; dbg_addr = 9'h020; dbg_wdata = 32'h55; dbg_func3 = 3'd2;
            at_sample();
            chk("wr_wait dbg_gnt", 32'(dbg_gnt), 32'(i == 3));
            chk("wr_wait mem_wr", 32'(mem_wr), 32'h1);
            chk("wr_wait mem_addr", 32'(mem_addr), (i < 3) ? 32'(9'h100 + i) : 32'h020);
            chk("wr_wait mem_wdata", mem_wdata, (i < 3) ? 32'(i + 1) : 32'h55);
        end
        next_cycle();
        clear_inputs();
        at_sample();

        // starvation: stall_req after 8 WAIT cycles, granted when the pipe frees
        do_reset();
        for (int i = 0; i < 13; i++) begin
            next_cycle();
            pipe_rd = (i < 12); pipe_addr = 9'h040;
            dbg_req = 1; dbg_we = 0; dbg_addr = 9'h0C0; dbg_func3 = 3'd2;
            mem_rdata = (i < 12) ? 32'h1111_0000 : 32'h600DCAFE;
            at_sample();
            chk($sformatf("starve c%0d stall_req", i), 32'(stall_req), 32'(i >= 9));
            chk($sformatf("starve c%0d dbg_gnt", i), 32'(dbg_gnt), 32'(i == 12));
        end
        chk("starve grant mem_addr", 32'(mem_addr), 32'h0C0);
        note_grant(1'b1, 1'b0, 32'h600DCAFE);
        next_cycle();
        clear_inputs();
        at_sample();
        chk("starve release stall_req", 32'(stall_req), 32'h0);

        // withdraw in WAIT with cnt=5: counter must restart from scratch
        do_reset();
        for (int i = 0; i < 17; i++) begin
            next_cycle();
            pipe_rd = 1; dbg_req = (i != 5); dbg_we = 0; dbg_addr = 9'h0AA;
            at_sample();
            chk($sformatf("withdraw c%0d stall_req", i), 32'(stall_req), 32'(i >= 15));
            chk($sformatf("withdraw c%0d dbg_gnt", i), 32'(dbg_gnt), 32'h0);
        end

        // async reset while dbg_rvalid is high
        do_reset();
        next_cycle();
        dbg_req = 1; dbg_we = 0; dbg_addr = 9'h010; mem_rdata = 32'hDEADBEEF;
        at_sample();
        chk("rst_rd dbg_gnt", 32'(dbg_gnt), 32'h1);
        note_grant(1'b1, 1'b0, 32'hDEADBEEF);
        next_cycle();
        clear_inputs();
        at_sample();
        #1 reset = 1'b0;
        #1;
        chk("rst_rd dbg_rvalid", 32'(dbg_rvalid), 32'h0);
        chk("rst_rd dbg_rdata", dbg_rdata, 32'h0);
        forget_pending();
        @(posedge clk);
        #1 reset = 1'b1;

        // async reset during STALL with a read pending and old read data held
        next_cycle();
        dbg_req = 1; dbg_we = 0; dbg_addr = 9'h010; mem_rdata = 32'h13579BDF;
        at_sample();
        note_grant(32'(dbg_gnt) == 32'h1, 1'b0, 32'h13579BDF);
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            pipe_rd = 1; dbg_req = 1; dbg_we = 0; dbg_addr = 9'h011; mem_rdata = 32'h0;
            at_sample();
        end
        chk("rst_stall stall_req before", 32'(stall_req), 32'h1);
        chk("rst_stall dbg_rdata before", dbg_rdata, 32'h13579BDF);
        #1 reset = 1'b0;
        #1;
        chk("rst_stall stall_req", 32'(stall_req), 32'h0);
        chk("rst_stall dbg_rvalid", 32'(dbg_rvalid), 32'h0);
        chk("rst_stall dbg_rdata", dbg_rdata, 32'h0);
        forget_pending();
        @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            pipe_rd = 1; dbg_req = 1;
            at_sample();
            chk("post_rst stall_req", 32'(stall_req), 32'h0);
        end
        next_cycle();
        clear_inputs();
        at_sample();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
